// File: rtl/a_add_rx_pkg.sv
// Shared types and helpers for the adder handshake receiver.
package a_add_rx_pkg;

  typedef enum logic {HS_IDLE = 1'b0, HS_ACK = 1'b1} hs_state_t;

  // Width of a counter that must hold every value 0..width inclusive.
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/hs_rx_chan.sv
// One 4-phase bundled-data receive channel: request synchronizer, handshake FSM
// and registered acknowledge. The capture strobe 'take' drives the caller's datapath.
module hs_rx_chan
  import a_add_rx_pkg::*;
#(
  parameter logic Rpol        = 1'b0,
  parameter int   SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic r,
  output logic a,
  input  logic accept_en,
  output logic take
);

  logic [SYNC_STAGES-1:0] r_sync_p;
  logic                   rq;
  hs_state_t              state, state_nxt;
  logic                   ack_nxt;

  assign rq = (r_sync_p[SYNC_STAGES-1] != Rpol);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync_p <= {SYNC_STAGES{Rpol}};
      state    <= HS_IDLE;
      a        <= Rpol;
    end else begin
      r_sync_p <= {r_sync_p[SYNC_STAGES-2:0], r};
      state    <= state_nxt;
      a        <= ack_nxt;
    end
  end

  // A pending request with accept_en low simply waits in HS_IDLE with ack idle.
  always_comb begin
    state_nxt = state;
    unique case (state)
      HS_IDLE: if (rq && accept_en) state_nxt = HS_ACK;
      HS_ACK:  if (!rq)             state_nxt = HS_IDLE;
    endcase
  end

  always_comb begin
    take    = (state == HS_IDLE) && rq && accept_en;
    ack_nxt = (state_nxt == HS_ACK) ? ~Rpol : Rpol;
  end

endmodule

// File: rtl/a_add_rx.sv
// Receiver for the adder's sum (bit-serial, LSB first) and carry handshake channels,
// assembling one word at a time onto a synchronous valid/ready output buffer.
module a_add_rx
  import a_add_rx_pkg::*;
#(
  parameter int   WIDTH       = 8,
  parameter logic Rpol        = 1'b0,
  parameter int   SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             r_s,
  output logic             a_s,
  input  logic             d_s,
  input  logic             r_c,
  output logic             a_c,
  input  logic             d_c,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry
);

  localparam int CNT_W = cnt_w(WIDTH);

  logic [CNT_W-1:0] bit_cnt;
  logic             carry_have;
  logic             carry_acc;
  logic [WIDTH-1:0] acc, acc_nxt;
  logic             take_s, take_c;
  logic             sum_en, carry_en;
  logic             complete, xfer;

  assign sum_en   = (bit_cnt < CNT_W'(WIDTH));
  assign carry_en = !carry_have;
  assign complete = (bit_cnt == CNT_W'(WIDTH)) && carry_have;
  assign xfer     = complete && (!o_valid || o_ready);

  hs_rx_chan #(.Rpol(Rpol), .SYNC_STAGES(SYNC_STAGES)) u_sum_chan (
    .clk       (clk),
    .rst       (rst),
    .r         (r_s),
    .a         (a_s),
    .accept_en (sum_en),
    .take      (take_s)
  );

  hs_rx_chan #(.Rpol(Rpol), .SYNC_STAGES(SYNC_STAGES)) u_carry_chan (
    .clk       (clk),
    .rst       (rst),
    .r         (r_c),
    .a         (a_c),
    .accept_en (carry_en),
    .take      (take_c)
  );

  always_comb begin
    acc_nxt = acc;
    for (int i = 0; i < WIDTH; i++)
      if (CNT_W'(i) == bit_cnt) acc_nxt[i] = d_s;
  end

  // Data accumulators need no reset: every bit is rewritten before a word is complete.
  always_ff @(posedge clk) begin
    if (take_s) acc       <= acc_nxt;
    if (take_c) carry_acc <= d_c;
  end

  // Handoff to the output buffer wins over any capture; the two never coincide
  // anyway because a complete word disables both accept_en.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt    <= '0;
      carry_have <= 1'b0;
      o_valid    <= 1'b0;
      o_sum      <= '0;
      o_carry    <= 1'b0;
    end else if (xfer) begin
      o_sum      <= acc;
      o_carry    <= carry_acc;
      o_valid    <= 1'b1;
      bit_cnt    <= '0;
      carry_have <= 1'b0;
    end else begin
      if (o_valid && o_ready) o_valid    <= 1'b0;
      if (take_s)             bit_cnt    <= bit_cnt + CNT_W'(1);
      if (take_c)             carry_have <= 1'b1;
    end
  end

endmodule
